// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop, EX operand/result and ALU broadcast signals of the ALU reservation station.
// The slave side is the reservation station; the master side is decode, LSB, EX and the ROB.
interface alu_rs_if #(
    parameter int ROB_W = 4
);
    logic             issue_valid;
    logic [5:0]       issue_order;
    logic [31:0]      issue_vj;
    logic [31:0]      issue_vk;
    logic             issue_rj_ready;
    logic             issue_rk_ready;
    logic [ROB_W-1:0] issue_qj;
    logic [ROB_W-1:0] issue_qk;
    logic [31:0]      issue_A;
    logic [31:0]      issue_pc;
    logic [ROB_W-1:0] issue_dest;
    logic             rs_full;

    logic             cdb_lsb_valid;
    logic [ROB_W-1:0] cdb_lsb_tag;
    logic [31:0]      cdb_lsb_value;

    logic [5:0]       ex_order;
    logic [31:0]      ex_vj;
    logic [31:0]      ex_vk;
    logic [31:0]      ex_A;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_value;
    logic [31:0]      ex_topc;

    logic             out_valid;
    logic [ROB_W-1:0] out_tag;
    logic [31:0]      out_value;
    logic [31:0]      out_topc;

    modport slave (
        input  issue_valid, issue_order, issue_vj, issue_vk, issue_rj_ready, issue_rk_ready,
        input  issue_qj, issue_qk, issue_A, issue_pc, issue_dest,
        input  cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_value,
        input  ex_value, ex_topc,
        output rs_full,
        output ex_order, ex_vj, ex_vk, ex_A, ex_pc,
        output out_valid, out_tag, out_value, out_topc
    );

    modport master (
        output issue_valid, issue_order, issue_vj, issue_vk, issue_rj_ready, issue_rk_ready,
        output issue_qj, issue_qk, issue_A, issue_pc, issue_dest,
        output cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_value,
        output ex_value, ex_topc,
        input  rs_full,
        input  ex_order, ex_vj, ex_vk, ex_A, ex_pc,
        input  out_valid, out_tag, out_value, out_topc
    );
endinterface

// File: rtl/alu_rs.sv
// Integer ALU reservation station: entries snoop the LSB CDB and the ALU's own broadcast,
// the lowest ready entry moves into a registered EX operand stage, and EX results are broadcast.
module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     clear_in,
    alu_rs_if.slave  bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_r;
    logic [RS_SIZE-1:0] rj_r;
    logic [RS_SIZE-1:0] rk_r;
    logic [5:0]         order_r [RS_SIZE];
    logic [31:0]        vj_r    [RS_SIZE];
    logic [31:0]        vk_r    [RS_SIZE];
    logic [31:0]        a_r     [RS_SIZE];
    logic [31:0]        pc_r    [RS_SIZE];
    logic [ROB_W-1:0]   qj_r    [RS_SIZE];
    logic [ROB_W-1:0]   qk_r    [RS_SIZE];
    logic [ROB_W-1:0]   dest_r  [RS_SIZE];

    logic               ex_valid_r;
    logic [ROB_W-1:0]   ex_dest_r;
    logic [5:0]         ex_order_r;
    logic [31:0]        ex_vj_r;
    logic [31:0]        ex_vk_r;
    logic [31:0]        ex_a_r;
    logic [31:0]        ex_pc_r;

    logic               out_valid_r;
    logic [ROB_W-1:0]   out_tag_r;
    logic [31:0]        out_value_r;
    logic [31:0]        out_topc_r;

    logic [IDX_W-1:0]   free_idx_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               sel_valid_s;
    logic               rs_full_s;
    logic [RS_SIZE-1:0] wake_j_s;
    logic [RS_SIZE-1:0] wake_k_s;
    logic [31:0]        wake_vj_s [RS_SIZE];
    logic [31:0]        wake_vk_s [RS_SIZE];
    logic               iss_j_hit_s;
    logic               iss_k_hit_s;
    logic [31:0]        iss_vj_s;
    logic [31:0]        iss_vk_s;

    // Tag match against both broadcast sources; LSB wins if both carry the same tag.
    function automatic logic [32:0] snoop(
        input logic [ROB_W-1:0] tag,
        input logic             lsb_valid,
        input logic [ROB_W-1:0] lsb_tag,
        input logic [31:0]      lsb_value,
        input logic             alu_valid,
        input logic [ROB_W-1:0] alu_tag,
        input logic [31:0]      alu_value
    );
        logic [32:0] res;
        if (lsb_valid && (lsb_tag == tag)) begin
            res = {1'b1, lsb_value};
        end else if (alu_valid && (alu_tag == tag)) begin
            res = {1'b1, alu_value};
        end else begin
            res = {1'b0, 32'h0000_0000};
        end
        return res;
    endfunction

    // Free-slot and ready-entry priority pick (lowest index), plus operand snooping.
    always_comb begin
        free_idx_s  = '0;
        sel_idx_s   = '0;
        sel_valid_s = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            free_idx_s  = busy_r[i] ? free_idx_s : IDX_W'(i);
            sel_idx_s   = (busy_r[i] && rj_r[i] && rk_r[i]) ? IDX_W'(i) : sel_idx_s;
            sel_valid_s = sel_valid_s | (busy_r[i] & rj_r[i] & rk_r[i]);
        end
        rs_full_s = &busy_r;
        for (int i = 0; i < RS_SIZE; i++) begin
            {wake_j_s[i], wake_vj_s[i]} = snoop(qj_r[i], bus.cdb_lsb_valid, bus.cdb_lsb_tag,
                                                bus.cdb_lsb_value, out_valid_r, out_tag_r, out_value_r);
            {wake_k_s[i], wake_vk_s[i]} = snoop(qk_r[i], bus.cdb_lsb_valid, bus.cdb_lsb_tag,
                                                bus.cdb_lsb_value, out_valid_r, out_tag_r, out_value_r);
        end
        {iss_j_hit_s, iss_vj_s} = snoop(bus.issue_qj, bus.cdb_lsb_valid, bus.cdb_lsb_tag,
                                        bus.cdb_lsb_value, out_valid_r, out_tag_r, out_value_r);
        {iss_k_hit_s, iss_vk_s} = snoop(bus.issue_qk, bus.cdb_lsb_valid, bus.cdb_lsb_tag,
                                        bus.cdb_lsb_value, out_valid_r, out_tag_r, out_value_r);
    end

    // Entry array: wakeup, release of the selected entry, and allocation of a new one.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            busy_r <= '0;
            rj_r   <= '0;
            rk_r   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                order_r[i] <= 6'd0;
                vj_r[i]    <= 32'h0000_0000;
                vk_r[i]    <= 32'h0000_0000;
                a_r[i]     <= 32'h0000_0000;
                pc_r[i]    <= 32'h0000_0000;
                qj_r[i]    <= '0;
                qk_r[i]    <= '0;
                dest_r[i]  <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_r[i] && !rj_r[i] && wake_j_s[i]) begin
                    rj_r[i] <= 1'b1;
                    vj_r[i] <= wake_vj_s[i];
                end
                if (busy_r[i] && !rk_r[i] && wake_k_s[i]) begin
                    rk_r[i] <= 1'b1;
                    vk_r[i] <= wake_vk_s[i];
                end
            end
            if (sel_valid_s) begin
                busy_r[sel_idx_s] <= 1'b0;
            end
            // The allocated slot is FREE, so it never collides with the wakeup or select writes above.
            if (bus.issue_valid && !rs_full_s) begin
                busy_r[free_idx_s]  <= 1'b1;
                order_r[free_idx_s] <= bus.issue_order;
                rj_r[free_idx_s]    <= bus.issue_rj_ready | iss_j_hit_s;
                rk_r[free_idx_s]    <= bus.issue_rk_ready | iss_k_hit_s;
                vj_r[free_idx_s]    <= bus.issue_rj_ready ? bus.issue_vj : iss_vj_s;
                vk_r[free_idx_s]    <= bus.issue_rk_ready ? bus.issue_vk : iss_vk_s;
                qj_r[free_idx_s]    <= bus.issue_qj;
                qk_r[free_idx_s]    <= bus.issue_qk;
                a_r[free_idx_s]     <= bus.issue_A;
                pc_r[free_idx_s]    <= bus.issue_pc;
                dest_r[free_idx_s]  <= bus.issue_dest;
            end
        end
    end

    // EX operand stage and result broadcast register.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            ex_valid_r  <= 1'b0;
            ex_dest_r   <= '0;
            ex_order_r  <= 6'd0;
            ex_vj_r     <= 32'h0000_0000;
            ex_vk_r     <= 32'h0000_0000;
            ex_a_r      <= 32'h0000_0000;
            ex_pc_r     <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            out_tag_r   <= '0;
            out_value_r <= 32'h0000_0000;
            out_topc_r  <= 32'h0000_0000;
        end else if (rdy_in) begin
            ex_valid_r  <= sel_valid_s;
            out_valid_r <= ex_valid_r;
            if (sel_valid_s) begin
                ex_dest_r  <= dest_r[sel_idx_s];
                ex_order_r <= order_r[sel_idx_s];
                ex_vj_r    <= vj_r[sel_idx_s];
                ex_vk_r    <= vk_r[sel_idx_s];
                ex_a_r     <= a_r[sel_idx_s];
                ex_pc_r    <= pc_r[sel_idx_s];
            end
            if (ex_valid_r) begin
                out_tag_r   <= ex_dest_r;
                out_value_r <= bus.ex_value;
                out_topc_r  <= bus.ex_topc;
            end
        end
    end

    assign bus.rs_full   = rs_full_s;
    assign bus.ex_order  = ex_order_r;
    assign bus.ex_vj     = ex_vj_r;
    assign bus.ex_vk     = ex_vk_r;
    assign bus.ex_A      = ex_a_r;
    assign bus.ex_pc     = ex_pc_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_tag   = out_tag_r;
    assign bus.out_value = out_value_r;
    assign bus.out_topc  = out_topc_r;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs with a small behavioural EX unit standing in for the real one.
module tb_alu_rs;
    localparam logic [5:0] OP_JALR = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd10;
    localparam logic [5:0] OP_ADD  = 6'd20;
    localparam logic [5:0] OP_SUB  = 6'd21;
    localparam logic [5:0] OP_AND  = 6'd29;
    localparam logic [5:0] OP_BEQ  = 6'd31;
    localparam logic [5:0] OP_BGEU = 6'd36;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic clr = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_rs_if #(.ROB_W(4)) bus ();

    alu_rs #(.RS_SIZE(8), .ROB_W(4)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rdy_in   (rdy),
        .clear_in (clr),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference EX unit: pure function of the registered operand stage.
    always_comb begin
        bus.ex_value = 32'h0;
        bus.ex_topc  = 32'h0;
        case (bus.ex_order)
            OP_JALR: begin
                bus.ex_value = bus.ex_pc + 32'd4;
                bus.ex_topc  = (bus.ex_vj + bus.ex_A) & ~32'd1;
            end
            OP_ADDI: bus.ex_value = bus.ex_vj + bus.ex_A;
            OP_ADD:  bus.ex_value = bus.ex_vj + bus.ex_vk;
            OP_SUB:  bus.ex_value = bus.ex_vj - bus.ex_vk;
            OP_AND:  bus.ex_value = bus.ex_vj & bus.ex_vk;
            OP_BEQ:  bus.ex_value = {31'd0, bus.ex_vj == bus.ex_vk};
            OP_BGEU: bus.ex_value = {31'd0, bus.ex_vj >= bus.ex_vk};
            default: bus.ex_value = 32'h0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic rj,
                             input logic [3:0] qj, input logic [31:0] vk, input logic rk,
                             input logic [3:0] qk, input logic [31:0] a, input logic [31:0] pc,
                             input logic [3:0] dest);
        bus.issue_valid    = 1'b1;
        bus.issue_order    = op;
        bus.issue_vj       = vj;
        bus.issue_rj_ready = rj;
        bus.issue_qj       = qj;
        bus.issue_vk       = vk;
        bus.issue_rk_ready = rk;
        bus.issue_qk       = qk;
        bus.issue_A        = a;
        bus.issue_pc       = pc;
        bus.issue_dest     = dest;
    endtask

    task automatic set_cdb(input logic v, input logic [3:0] tag, input logic [31:0] value);
        bus.cdb_lsb_valid = v;
        bus.cdb_lsb_tag   = tag;
        bus.cdb_lsb_value = value;
    endtask

    task automatic check_out(input string tag, input logic [3:0] t, input logic [31:0] v,
                             input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".tag"},   {28'd0, bus.out_tag},   {28'd0, t});
        check({tag, ".value"}, bus.out_value, v);
        check({tag, ".topc"},  bus.out_topc,  pc);
    endtask

    initial begin
        set_issue(6'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        bus.issue_valid = 1'b0;
        set_cdb(1'b0, 4'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        check("reset.rs_full",   {31'd0, bus.rs_full},   32'd0);
        check("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset.out_tag",   {28'd0, bus.out_tag},   32'd0);
        check("reset.out_value", bus.out_value,          32'd0);
        check("reset.ex_order",  {26'd0, bus.ex_order},  32'd0);
        check("reset.ex_vj",     bus.ex_vj,              32'd0);

        // Basic ADD: 5 + 7 -> tag 3
        set_issue(OP_ADD, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'd0, 32'd0, 4'd3);
        tick();
        bus.issue_valid = 1'b0;
        check("add.e0_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("add.ex_order", {26'd0, bus.ex_order}, {26'd0, OP_ADD});
        check("add.ex_vj", bus.ex_vj, 32'd5);
        check("add.ex_vk", bus.ex_vk, 32'd7);
        check("add.e1_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check_out("add.out", 4'd3, 32'd12, 32'd0);
        tick();
        check("add.pulse_end", {31'd0, bus.out_valid}, 32'd0);

        // Dependent ADDI: waits on tag 2, woken by LSB value 10, A = -1
        set_issue(OP_ADDI, 32'd0, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd0, 4'd5);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        set_cdb(1'b1, 4'd2, 32'd10);
        tick();
        set_cdb(1'b0, 4'd0, 32'd0);
        check("addi.w0_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("addi.w1_valid", {31'd0, bus.out_valid}, 32'd0);
        check("addi.ex_vj", bus.ex_vj, 32'd10);
        tick();
        check_out("addi.out", 4'd5, 32'd9, 32'd0);
        tick();
        check("addi.pulse_end", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back chain through self-wakeup
        set_issue(OP_SUB, 32'd20, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 32'd0, 32'd0, 4'd1);
        tick();
        set_issue(OP_AND, 32'd0, 1'b0, 4'd1, 32'h0000_000F, 1'b1, 4'd0, 32'd0, 32'd0, 4'd2);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        check_out("chain.sub", 4'd1, 32'd12, 32'd0);
        tick();
        check("chain.e3_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("chain.ex_vj", bus.ex_vj, 32'd12);
        tick();
        check_out("chain.and", 4'd2, 32'd12, 32'd0);
        tick();
        check("chain.pulse_end", {31'd0, bus.out_valid}, 32'd0);

        // Full: 8 ADDIs waiting on tag 7, a 9th ignored, then drained lowest first
        for (int i = 0; i < 7; i++) begin
            set_issue(OP_ADDI, 32'd0, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'(i), 32'd0, 4'(8 + i));
            tick();
        end
        check("full.seven", {31'd0, bus.rs_full}, 32'd0);
        set_issue(OP_ADDI, 32'd0, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd7, 32'd0, 4'd15);
        tick();
        check("full.eight", {31'd0, bus.rs_full}, 32'd1);
        set_issue(OP_ADD, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0);
        tick();
        bus.issue_valid = 1'b0;
        check("full.ninth_full", {31'd0, bus.rs_full}, 32'd1);
        set_cdb(1'b1, 4'd7, 32'd100);
        tick();
        set_cdb(1'b0, 4'd0, 32'd0);
        check("full.w0_valid", {31'd0, bus.out_valid}, 32'd0);
        check("full.w0_full", {31'd0, bus.rs_full}, 32'd1);
        tick();
        check("full.w1_full", {31'd0, bus.rs_full}, 32'd0);
        check("full.w1_valid", {31'd0, bus.out_valid}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("full.drain_valid", {31'd0, bus.out_valid}, 32'd1);
            check("full.drain_tag", {28'd0, bus.out_tag}, 32'(8 + k));
            check("full.drain_value", bus.out_value, 32'(100 + k));
        end
        tick();
        check("full.no_ninth", {31'd0, bus.out_valid}, 32'd0);

        // Issue-cycle capture with JALR
        set_issue(OP_JALR, 32'd0, 1'b0, 4'd4, 32'd0, 1'b1, 4'd0, 32'd4, 32'h0000_0100, 4'd6);
        set_cdb(1'b1, 4'd4, 32'h0000_1001);
        tick();
        bus.issue_valid = 1'b0;
        set_cdb(1'b0, 4'd0, 32'd0);
        tick();
        tick();
        check_out("jalr.out", 4'd6, 32'h0000_0104, 32'h0000_1004);
        tick();
        check("jalr.pulse_end", {31'd0, bus.out_valid}, 32'd0);

        // Both sources broadcast tag 2 in one cycle: the LSB value must win
        set_issue(OP_ADD, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 32'd0, 32'd0, 4'd2);
        tick();
        set_issue(OP_ADDI, 32'd0, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd3);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        check_out("dual.alu", 4'd2, 32'd7, 32'd0);
        set_cdb(1'b1, 4'd2, 32'd50);
        tick();
        set_cdb(1'b0, 4'd0, 32'd0);
        tick();
        tick();
        check_out("dual.lsb_wins", 4'd3, 32'd50, 32'd0);

        // Branch flags on consecutive cycles
        set_issue(OP_BEQ, 32'd3, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd0, 32'h0000_0200, 4'd4);
        tick();
        set_issue(OP_BGEU, 32'd2, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd0, 32'h0000_0204, 4'd5);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        check_out("br.beq", 4'd4, 32'd1, 32'd0);
        tick();
        check_out("br.bgeu", 4'd5, 32'd0, 32'd0);

        // Mid-operation clear: three waiting entries plus one in the EX stage
        for (int i = 0; i < 3; i++) begin
            set_issue(OP_ADD, 32'd0, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0, 4'(1 + i));
            tick();
        end
        set_issue(OP_ADD, 32'd2, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd0, 32'd0, 4'd4);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        check("clr.ex_loaded", bus.ex_vj, 32'd2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("clr.rs_full",   {31'd0, bus.rs_full},   32'd0);
        check("clr.ex_order",  {26'd0, bus.ex_order},  32'd0);
        check("clr.ex_vj",     bus.ex_vj,              32'd0);
        check("clr.out_value", bus.out_value,          32'd0);
        set_cdb(1'b1, 4'd9, 32'd77);
        tick();
        set_cdb(1'b0, 4'd0, 32'd0);
        tick();
        check("clr.quiet1", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("clr.quiet2", {31'd0, bus.out_valid}, 32'd0);
        set_issue(OP_ADD, 32'd2, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd0, 32'd0, 4'd7);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        tick();
        check_out("clr.fresh", 4'd7, 32'd5, 32'd0);

        // rdy low freezes everything, including an attempted issue
        set_issue(OP_ADD, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd0, 32'd0, 4'd5);
        tick();
        rdy = 1'b0;
        set_issue(OP_ADD, 32'd9, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 32'd0, 32'd0, 4'd6);
        tick();
        bus.issue_valid = 1'b0;
        tick();
        check("stall.ex_vj", bus.ex_vj, 32'd2);
        check("stall.out_valid", {31'd0, bus.out_valid}, 32'd0);
        rdy = 1'b1;
        tick();
        check("stall.ex_resume", bus.ex_vj, 32'd1);
        tick();
        check_out("stall.out", 4'd5, 32'd3, 32'd0);
        rdy = 1'b0;
        tick();
        check("stall.hold_tag", {28'd0, bus.out_tag}, 32'd5);
        check("stall.hold_value", bus.out_value, 32'd3);
        rdy = 1'b1;
        tick();
        check("stall.pulse_end", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("stall.no_ignored", {31'd0, bus.out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
